shift_register_burst: RTL and testbench
=======================================

// Module: shift_register_burst
// PURPOSE
//  W-bit universal shift register, parametrised successor of the 4-bit part.
//  Modes: serial shift, circular shift, parallel load and hold.
//  Adds a counted "burst" shift: a START/BUSY/DONE handshake executes AMT shift steps autonomously.
//  Sits between the stimulus/test modules and the datapath; Q and S_OUT keep their existing meaning.
// PARAMETERS
//  W   4               register width, >= 2
//  AW  $clog2(W+1)     width of AMT (derived, covers 0..W)
// PORTS
//  CLK    in   1   single clock, rising edge
//  RST    in   1   synchronous, active-high reset
//  ENB    in   1   1 = register/FSM advance; 0 = everything holds (incl. burst)
//  DIR    in   1   1 = shift right (toward bit 0), 0 = shift left
//  S_IN   in   1   serial input bit, enters MSB (right) / LSB (left)
//  MODO   in   2   00 SERIAL_SHIFT, 01 CIRC_SHIFT, 10 PARA_LOAD, 11 HOLD
//  D      in   W   parallel load data
//  START  in   1   request burst of AMT steps (shift modes only)
//  AMT    in   AW  burst step count, 0..W
//  Q      out  W   register contents
//  S_OUT  out  1   next departing bit: DIR ? Q[0] : Q[W-1] (combinational from Q)
//  BUSY   out  1   burst in progress, inputs other than ENB/S_IN/RST ignored
//  DONE   out  1   one-cycle pulse, burst finished
// BEHAVIOUR
//  Reset (edge with RST=1, overrides all): Q=0, BUSY=0, DONE=0, FSM=IDLE, count=0; S_OUT=0 via Q.
//  ENB=0: Q, FSM, counter and DONE all hold their values; a DONE pulse is stretched until ENB returns.
//  FSM states: IDLE, SHIFT.
//  IDLE, ENB=1, START=0 (or START=1 with MODO in {PARA_LOAD, HOLD}): one op per edge.
//   SERIAL: right Q<={S_IN,Q[W-1:1]}, left Q<={Q[W-2:0],S_IN}.
//   CIRC:   right Q<={Q[0],Q[W-1:1]}, left Q<={Q[W-2:0],Q[W-1]}.
//   LOAD:   Q<=D.  HOLD: Q unchanged.  DONE<=0.
//  IDLE, ENB=1, START=1, MODO in {SERIAL, CIRC}: accepted at edge k; MODO and DIR latched.
//   AMT=0: no shift, DONE=1 after edge k, stay IDLE.
//   AMT=1: shift at edge k, DONE=1 after edge k, stay IDLE (BUSY never rises).
//   AMT>=2: shift at edge k, count<=AMT-1, go SHIFT, BUSY=1.
//  SHIFT, ENB=1: one step per edge using latched mode/dir; live S_IN used in serial mode.
//   Count decrements; the step with count==1 -> IDLE, BUSY=0, DONE=1.
//   Net: shifts at edges k..k+AMT-1; DONE high for the cycle after edge k+AMT-1.
//  AMT > W is saturated to W.
//  DONE clears on the next enabled edge.
//  START while BUSY is ignored; a back-to-back START may be accepted in the DONE cycle.
//  RST mid-burst aborts: no DONE; Q=0.
// STRUCTURE
//  shift_reg_pkg: MODO localparams (SERIAL_SHIFT, CIRC_SHIFT, PARA_LOAD, HOLD),
//   FSM state encodings (IDLE, SHIFT).
//  Sub-module shift_reg_step (combinational): (Q, mode, DIR, S_IN, D) -> next Q.
//   Shared by the per-cycle and burst paths.
//  Top: FSM, AW-bit down-counter, latched mode/dir, Q register, DONE/BUSY flops.
// TESTING
//  1 W=4, LOAD D=0001, START CIRC DIR=1 AMT=3 -> Q 1000,0100,0010 on 3 edges; DONE 1 cycle after edge 3; BUSY 2 cycles.
//  2 Q=0000, SERIAL DIR=0 S_IN=1, no START, 4 edges -> Q=1111; S_OUT tracks Q[3] (0,0,0,1).
//  3 START AMT=0 -> Q unchanged, DONE one cycle, BUSY stays 0; AMT=1 -> one shift + DONE, no BUSY.
//  4 Burst AMT=4 with ENB=0 for 2 cycles mid-burst -> Q/count frozen; completes 2 cycles late; result = 4-step rotate.
//  5 RST=1 mid-burst -> next edge Q=0000, BUSY=0, DONE never pulses; START/MODO/D changes while BUSY have no effect.
//  6 W=8: LOAD 0x81, CIRC left AMT=8 -> Q back to 0x81; AMT=9 saturates to 8, same result.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: mode codes and burst FSM states shared by the shift register files
package shift_reg_pkg;
    localparam logic [1:0] SERIAL_SHIFT = 2'b00;
    localparam logic [1:0] CIRC_SHIFT   = 2'b01;
    localparam logic [1:0] PARA_LOAD    = 2'b10;
    localparam logic [1:0] HOLD         = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Only the two shift modes may start a counted burst.
    function automatic logic is_shift_mode(input logic [1:0] mode);
        return !mode[1];
    endfunction
endpackage

// File: rtl/shift_reg_step.sv
// shift_reg_step: one combinational register update for a given mode and direction
module shift_reg_step
    import shift_reg_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] q,
    input  logic [1:0]   mode,
    input  logic         dir,
    input  logic         s_in,
    input  logic [W-1:0] d,
    output logic [W-1:0] q_next
);
    logic in_bit;

    // Circular mode feeds back the departing bit, serial mode takes s_in.
    always_comb begin
        in_bit = (mode == CIRC_SHIFT) ? (dir ? q[0] : q[W-1]) : s_in;
        q_next = (mode == PARA_LOAD) ? d :
                 (mode == HOLD)      ? q :
                 dir                 ? {in_bit, q[W-1:1]} : {q[W-2:0], in_bit};
    end
endmodule

// File: rtl/shift_register_burst.sv
// shift_register_burst: universal shift register with a counted START/BUSY/DONE burst shift
module shift_register_burst
    import shift_reg_pkg::*;
#(
    parameter int W  = 4,
    parameter int AW = $clog2(W + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ENB,
    input  logic          DIR,
    input  logic          S_IN,
    input  logic [1:0]    MODO,
    input  logic [W-1:0]  D,
    input  logic          START,
    input  logic [AW-1:0] AMT,
    output logic [W-1:0]  Q,
    output logic          S_OUT,
    output logic          BUSY,
    output logic          DONE
);
    state_t        state, state_n;
    logic [AW-1:0] cnt, cnt_n, amt_sat;
    logic [1:0]    mode_l, mode_n, step_mode;
    logic          dir_l, dir_n, step_dir;
    logic          done_n, burst_req;
    logic [W-1:0]  q_n, step_q;

    // A running burst uses the mode/direction captured at START, otherwise the live inputs.
    assign step_mode = (state == SHIFT) ? mode_l : MODO;
    assign step_dir  = (state == SHIFT) ? dir_l : DIR;
    assign amt_sat   = (AMT > AW'(W)) ? AW'(W) : AMT;
    assign burst_req = START && is_shift_mode(MODO);
    assign BUSY      = (state == SHIFT);
    assign S_OUT     = DIR ? Q[0] : Q[W-1];

    shift_reg_step #(.W(W)) u_step (
        .q      (Q),
        .mode   (step_mode),
        .dir    (step_dir),
        .s_in   (S_IN),
        .d      (D),
        .q_next (step_q)
    );

    // Next-state logic: ENB low freezes everything, including a pending DONE pulse.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mode_n  = mode_l;
        dir_n   = dir_l;
        done_n  = DONE;
        q_n     = Q;
        if (ENB) begin
            done_n = 1'b0;
            if (state == SHIFT) begin
                q_n   = step_q;
                cnt_n = cnt - 1'b1;
                if (cnt == AW'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end else if (burst_req) begin
                mode_n = MODO;
                dir_n  = DIR;
                q_n    = (amt_sat != '0) ? step_q : Q;
                if (amt_sat <= AW'(1)) begin
                    done_n = 1'b1;
                end else begin
                    cnt_n   = amt_sat - 1'b1;
                    state_n = SHIFT;
                end
            end else begin
                q_n = step_q;
            end
        end
    end

    // State, counter, latched burst settings, register contents and DONE flop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_l <= SERIAL_SHIFT;
            dir_l  <= 1'b0;
            Q      <= '0;
            DONE   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            mode_l <= mode_n;
            dir_l  <= dir_n;
            Q      <= q_n;
            DONE   <= done_n;
        end
    end
endmodule

// File: tb/tb_shift_register_burst.sv
// tb_shift_register_burst: directed and randomized checks against a behavioural model
module tb_shift_register_burst;
    localparam int W  = 4;
    localparam int AW = $clog2(W + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, enb = 1'b0, dir = 1'b0, s_in = 1'b0, start = 1'b0;
    logic [1:0]    modo = 2'b11;
    logic [W-1:0]  d = '0;
    logic [AW-1:0] amt = '0;
    logic [W-1:0]  q;
    logic          s_out, busy, done;

    logic       rst8 = 1'b1, enb8 = 1'b0, dir8 = 1'b0, s_in8 = 1'b0, start8 = 1'b0;
    logic [1:0] modo8 = 2'b11;
    logic [7:0] d8 = '0;
    logic [3:0] amt8 = '0;
    logic [7:0] q8;
    logic       s_out8, busy8, done8;

    int vectors = 0;
    int miscompares = 0;

    shift_register_burst #(.W(W)) dut (
        .CLK(clk), .RST(rst), .ENB(enb), .DIR(dir), .S_IN(s_in), .MODO(modo), .D(d),
        .START(start), .AMT(amt), .Q(q), .S_OUT(s_out), .BUSY(busy), .DONE(done)
    );

    shift_register_burst #(.W(8)) dut8 (
        .CLK(clk), .RST(rst8), .ENB(enb8), .DIR(dir8), .S_IN(s_in8), .MODO(modo8), .D(d8),
        .START(start8), .AMT(amt8), .Q(q8), .S_OUT(s_out8), .BUSY(busy8), .DONE(done8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register value, steps still owed by a burst, DONE level.
    int mq = 0, rem = 0;
    bit mdone = 0, mcirc = 0, mdir = 0, live = 0;

    function automatic int step(input int v, input bit circ, input bit right, input bit sin);
        int ent;
        ent = circ ? (right ? (v & 1) : ((v >> (W - 1)) & 1)) : int'(sin);
        return right ? ((v >> 1) | (ent << (W - 1))) : (((v << 1) | ent) & ((1 << W) - 1));
    endfunction

    always @(posedge clk) begin : model
        int n;
        if (rst) begin
            mq = 0; rem = 0; mdone = 0; live = 1;
        end else if (enb && live) begin
            if (rem > 0) begin
                mq = step(mq, mcirc, mdir, s_in);
                rem--;
                mdone = (rem == 0);
            end else if (start && !modo[1]) begin
                n = (int'(amt) > W) ? W : int'(amt);
                mcirc = modo[0];
                mdir = dir;
                if (n > 0) mq = step(mq, mcirc, mdir, s_in);
                rem = (n > 0) ? n - 1 : 0;
                mdone = (n <= 1);
            end else begin
                mdone = 0;
                if (modo == 2'b00) mq = step(mq, 1'b0, dir, s_in);
                else if (modo == 2'b01) mq = step(mq, 1'b1, dir, s_in);
                else if (modo == 2'b10) mq = int'(d);
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (live) begin
            check("q", 32'(q), 32'(mq));
            check("s_out", 32'(s_out), 32'(dir ? (mq & 1) : ((mq >> (W - 1)) & 1)));
            check("busy", 32'(busy), 32'(rem > 0));
            check("done", 32'(done), 32'(mdone));
        end
    end

    task automatic edge_;
        @(negedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] m, input logic dr, input logic si, input logic st,
                      input logic [AW-1:0] a, input logic [W-1:0] dd);
        modo = m; dir = dr; s_in = si; start = st; amt = a; d = dd;
    endtask

    initial begin
        edge_;
        rst = 0; enb = 1;
        // 1: load 0001, circular right burst of 3
        op(2'b10, 0, 0, 0, 0, 4'b0001); edge_;
        check("t1_load", 32'(q), 32'h1);
        op(2'b01, 1, 0, 1, 3, 0); edge_;
        check("t1_q1", 32'(q), 32'h8); check("t1_busy1", 32'(busy), 1);
        op(2'b11, 0, 0, 0, 0, 0); edge_;
        check("t1_q2", 32'(q), 32'h4); check("t1_busy2", 32'(busy), 1);
        edge_;
        check("t1_q3", 32'(q), 32'h2); check("t1_done", 32'(done), 1); check("t1_busy3", 32'(busy), 0);
        edge_;
        check("t1_done_clr", 32'(done), 0);
        // 2: serial left fill with ones
        op(2'b10, 0, 0, 0, 0, 4'b0000); edge_;
        op(2'b00, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            edge_;
            check("t2_q", 32'(q), 32'((1 << i) - 1));
            check("t2_sout", 32'(s_out), 32'(i == 4));
        end
        // 3: AMT=0 and AMT=1 bursts
        op(2'b01, 0, 0, 1, 0, 0); edge_;
        check("t3_q0", 32'(q), 32'hF); check("t3_done0", 32'(done), 1); check("t3_busy0", 32'(busy), 0);
        op(2'b10, 0, 0, 0, 0, 4'b0011); edge_;
        check("t3_done_clr", 32'(done), 0);
        op(2'b01, 0, 0, 1, 1, 0); edge_;
        check("t3_q1", 32'(q), 32'h6); check("t3_done1", 32'(done), 1); check("t3_busy1", 32'(busy), 0);
        // 4: 4-step rotate with a two-cycle ENB pause
        op(2'b10, 0, 0, 0, 0, 4'b0001); edge_;
        op(2'b01, 0, 0, 1, 4, 0); edge_;
        check("t4_q1", 32'(q), 32'h2);
        op(2'b11, 0, 0, 0, 0, 0); enb = 0; edge_; edge_;
        check("t4_frozen", 32'(q), 32'h2); check("t4_busy_frz", 32'(busy), 1);
        enb = 1; edge_; edge_; edge_;
        check("t4_q", 32'(q), 32'h1); check("t4_done", 32'(done), 1);
        enb = 0; edge_;
        check("t4_done_hold", 32'(done), 1);
        enb = 1; edge_;
        check("t4_done_clr", 32'(done), 0);
        // 5: reset mid-burst, inputs ignored while busy
        op(2'b10, 0, 0, 0, 0, 4'b1010); edge_;
        op(2'b00, 1, 1, 1, 4, 0); edge_;
        check("t5_q1", 32'(q), 32'hD);
        op(2'b10, 0, 0, 1, 0, 4'b0000); edge_;
        check("t5_q2", 32'(q), 32'h6); check("t5_busy", 32'(busy), 1);
        rst = 1; edge_;
        check("t5_rst_q", 32'(q), 0); check("t5_rst_busy", 32'(busy), 0);
        rst = 0; op(2'b11, 0, 0, 0, 0, 0); edge_; edge_;
        check("t5_no_done", 32'(done), 0);
        // 6: W=8 full rotate and saturation
        edge_;
        rst8 = 0; enb8 = 1; modo8 = 2'b10; d8 = 8'h81; edge_;
        for (int k = 8; k <= 9; k++) begin
            modo8 = 2'b01; dir8 = 0; start8 = 1; amt8 = 4'(k); edge_;
            start8 = 0; modo8 = 2'b11;
            for (int i = 2; i <= 7; i++) edge_;
            check("t6_q7", 32'(q8), 32'hC0); check("t6_busy", 32'(busy8), 1);
            edge_;
            check("t6_q8", 32'(q8), 32'h81); check("t6_done", 32'(done8), 1);
            edge_;
        end
        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(63) == 0);
            enb = ($urandom_range(9) < 8);
            start = ($urandom_range(3) == 0);
            modo = 2'($urandom);
            dir = 1'($urandom);
            s_in = 1'($urandom);
            amt = AW'($urandom_range(7));
            d = W'($urandom);
            edge_;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
